seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider for the ALU. It is the inverse datapath of the ripple-carry adder chain: the adder chain adds, this block repeatedly subtracts and restores.
- Accepts one dividend/divisor pair through a valid/ready handshake.
- Performs one subtract-and-shift step per clock and returns quotient and remainder through a second valid/ready handshake.
- Serves as the division resource for the DSP datapath where a single-cycle divider is too large.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal values are multiples of 4, minimum 4.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  block can accept an operation.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- out_valid  output  1  results valid.
- out_ready  input  1  consumer accepts results.
- quotient  output  WIDTH  integer quotient.
- remainder  output  WIDTH  remainder.
- div_by_zero  output  1  the completed operation had divisor == 0.

Behaviour:
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. in_ready = (state==IDLE), so it reads 1 during and after reset.
- Accept: transfer occurs on an edge where in_valid && in_ready. Operands are registered. Inputs in other cycles are ignored.
- Normal path: IDLE→BUSY on accept.
  - Working registers: R (WIDTH+1 bits) cleared to 0; Q loaded with dividend; D loaded with divisor.
  - Each BUSY edge: R' = {R[WIDTH-1:0], Q[WIDTH-1]}; T = R' − {0,D}.
  - If no borrow: R=T, Q={Q[WIDTH-2:0],1}. Otherwise: R=R', Q={Q[WIDTH-2:0],0}.
  - After exactly WIDTH BUSY edges, the state goes to DONE.
  - quotient=Q, remainder=R[WIDTH-1:0]. out_valid is first high WIDTH cycles after the accept edge.
- Divide by zero: if the accepted divisor==0, the next edge goes directly to DONE with quotient=all ones, remainder=dividend, div_by_zero=1. Latency is 1 cycle.
- div_by_zero=0 for every nonzero-divisor result.
- DONE: out_valid=1; quotient, remainder and div_by_zero are held stable until out_valid && out_ready.
  - On that edge the state goes to IDLE and out_valid=0. Result registers keep their last values.
  - in_ready=0 in BUSY and DONE. There is no overlap between operations, so the earliest next accept is the cycle after result handoff.
- Invariant: dividend = quotient*divisor + remainder, with remainder < divisor, for all divisor≠0.
- Reset mid-operation (any state): asynchronous return to IDLE with all reset values. The partial result is discarded and out_valid never pulses.
- An in_valid held high through BUSY/DONE is not consumed until IDLE.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- When defined:
  - Adds input signed_op (1 bit), sampled at accept.
  - When signed_op=1, operands are two's complement. Magnitudes are divided by the same engine.
  - The quotient is negated if the operand signs differ (truncation toward zero). The remainder takes the sign of the dividend. Sign fix-up is applied on BUSY→DONE and adds no cycles.
  - Most-negative / −1 gives quotient=most-negative, remainder=0, div_by_zero=0.
  - Signed divide by zero gives quotient=all ones, remainder=dividend, div_by_zero=1.
- When undefined: the port is absent and all operation is unsigned, exactly as above.

Decomposition:
- Package seq_divider_pkg contains:
  - state enum (IDLE, BUSY, DONE);
  - counter width constant CNT_W = $clog2(WIDTH+1);
  - the divide-by-zero quotient constant (all ones).
- One sub-module, borrow_sub: a WIDTH-bit ripple-borrow subtractor built from 4-bit sections chained by borrow. It outputs the difference and the final borrow. It is instantiated once for the trial subtraction.
- The FSM, counter and shift registers stay in seq_divider.

Test Plan:
- WIDTH=8, dividend=200, divisor=7 → quotient=28, remainder=4, div_by_zero=0; out_valid first high 8 cycles after the accept edge.
- dividend=5, divisor=0 → quotient=255, remainder=5, div_by_zero=1; out_valid 1 cycle after accept.
- dividend=3, divisor=10 → quotient=0, remainder=3. Then dividend=255, divisor=1 → quotient=255, remainder=0. Back-to-back: second accept occurs the cycle after the first handoff.
- 100/9 with out_ready held low 5 cycles in DONE → outputs stable at 11/1, in_ready=0 throughout, handoff on the cycle out_ready rises.
- Reset: rst_n low 4 edges into a 200/7 operation → immediate IDLE, out_valid=0, outputs 0, in_ready=1. A fresh 50/5 after release → 10/0.
- With SEQ_DIVIDER_SIGNED_EN, signed_op=1:
  - −7/2 → quotient=−3 (0xFD), remainder=−1 (0xFF);
  - −128/−1 → quotient=0x80, remainder=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// seq_divider_pkg : shared types and constants for the restoring divider
// Rev 1.0
// ============================================================================
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Iteration counter width for a given operand width
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

   // Quotient reported for divide-by-zero; sliced to WIDTH by the user
   localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage
`default_nettype wire

// File: rtl/seq_divider_borrow_sub.sv
`default_nettype none
// ============================================================================
// borrow_sub : WIDTH-bit ripple-borrow subtractor of 4-bit sections
// Rev 1.0
// ============================================================================
module borrow_sub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int SECTIONS = WIDTH / 4;

   logic [SECTIONS:0] w_chain;

   assign w_chain[0] = 1'b0;

   // Bit 4 of each 5-bit section result is the sign, i.e. the borrow out
   for (genvar i = 0; i < SECTIONS; i++) begin : g_section
      logic [4:0] w_sec;
      assign w_sec = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0000, w_chain[i]};
      assign diff[4*i +: 4] = w_sec[3:0];
      assign w_chain[i+1]   = w_sec[4];
   end

   assign borrow = w_chain[SECTIONS];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// seq_divider : multi-cycle restoring divider, one quotient bit per clock
// Optional signed mode: define SEQ_DIVIDER_SIGNED_EN.  Rev 1.0
// ============================================================================
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef SEQ_DIVIDER_SIGNED_EN
   input  logic             signed_op,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int                  CNT_WIDTH = cnt_width(WIDTH);
   localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(WIDTH - 1);

   state_t               r_state;
   state_t               w_state_next;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_q;
   logic [WIDTH-1:0]     r_d;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_dbz_pend;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic [WIDTH-1:0]     r_quotient;
   logic [WIDTH-1:0]     r_remainder;
   logic                 r_div_by_zero;

   logic                 w_neg_dvd;
   logic                 w_neg_dvs;
   logic [WIDTH-1:0]     w_dvd_mag;
   logic [WIDTH-1:0]     w_dvs_mag;
   logic [WIDTH:0]       w_shift;
   logic [WIDTH-1:0]     w_diff;
   logic                 w_borrow;
   logic                 w_fits;
   logic [WIDTH-1:0]     w_rem_next;
   logic [WIDTH-1:0]     w_q_next;
   logic                 w_last;

`ifdef SEQ_DIVIDER_SIGNED_EN
   assign w_neg_dvd = signed_op & dividend[WIDTH-1];
   assign w_neg_dvs = signed_op & divisor[WIDTH-1];
`else
   assign w_neg_dvd = 1'b0;
   assign w_neg_dvs = 1'b0;
`endif
   assign w_dvd_mag = w_neg_dvd ? -dividend : dividend;
   assign w_dvs_mag = w_neg_dvs ? -divisor  : divisor;

   // The partial remainder is always below the divisor, so its extra top bit
   // is only needed in the shifted value R' and is not stored.
   assign w_shift = {r_rem, r_q[WIDTH-1]};

   borrow_sub #(.WIDTH(WIDTH)) u_trial (
      .a      (w_shift[WIDTH-1:0]),
      .b      (r_d),
      .diff   (w_diff),
      .borrow (w_borrow)
   );

   assign w_fits     = w_shift[WIDTH] | ~w_borrow;
   assign w_rem_next = w_fits ? w_diff : w_shift[WIDTH-1:0];
   assign w_q_next   = {r_q[WIDTH-2:0], w_fits};
   assign w_last     = (r_state == BUSY) && (r_dbz_pend || (r_cnt == LAST_STEP));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = BUSY;
         end
         BUSY: begin
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem         <= '0;
         r_q           <= '0;
         r_d           <= '0;
         r_cnt         <= '0;
         r_dbz_pend    <= 1'b0;
         r_neg_q       <= 1'b0;
         r_neg_r       <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
      end else if (in_valid && in_ready) begin
         r_rem      <= '0;
         r_cnt      <= '0;
         r_d        <= w_dvs_mag;
         r_dbz_pend <= (divisor == '0);
         // Raw dividend kept for divide-by-zero so the remainder echoes it
         r_q        <= (divisor == '0) ? dividend : w_dvd_mag;
         r_neg_q    <= w_neg_dvd ^ w_neg_dvs;
         r_neg_r    <= w_neg_dvd;
      end else if (r_state == BUSY) begin
         if (r_dbz_pend) begin
            r_quotient    <= DBZ_QUOTIENT[WIDTH-1:0];
            r_remainder   <= r_q;
            r_div_by_zero <= 1'b1;
         end else begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (r_cnt == LAST_STEP) begin
               r_quotient    <= r_neg_q ? -w_q_next   : w_q_next;
               r_remainder   <= r_neg_r ? -w_rem_next : w_rem_next;
               r_div_by_zero <= 1'b0;
            end
         end
      end
   end

   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// tb_seq_divider : directed self-checking bench for seq_divider (WIDTH=8)
// Rev 1.0
// ============================================================================
module tb_seq_divider;

   logic       clk;
   logic       rst_n;
   logic       signed_op;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int errors = 0;
   int checks = 0;

   seq_divider #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef SEQ_DIVIDER_SIGNED_EN
      .signed_op   (signed_op),
`endif
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present operands for one edge; returns with time #1 after the accept edge
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
      @(negedge clk);
      dividend  = a;
      divisor   = b;
      signed_op = s;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Edges after the accept edge until out_valid is seen (bounded)
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 40) begin
         @(posedge clk);
         #1 cycles++;
      end
   endtask

   task automatic handoff();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; signed_op = 1'b0;
      dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (quotient !== 8'd0)    begin errors++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
      checks++; if (remainder !== 8'd0)   begin errors++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
      rst_n = 1'b1;
   endtask

   task automatic test_normal();
      int cyc;
      start_op(8'd200, 8'd7, 1'b0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready got=%b exp=0", in_ready); end
      wait_done(cyc);
      checks++; if (cyc != 8)              begin errors++; $display("FAIL normal_latency got=%0d exp=8", cyc); end
      checks++; if (quotient !== 8'd28)    begin errors++; $display("FAIL normal_quotient got=%0d exp=28", quotient); end
      checks++; if (remainder !== 8'd4)    begin errors++; $display("FAIL normal_remainder got=%0d exp=4", remainder); end
      checks++; if (div_by_zero !== 1'b0)  begin errors++; $display("FAIL normal_dbz got=%b exp=0", div_by_zero); end
      checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL done_in_ready got=%b exp=0", in_ready); end
      handoff();
      checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL normal_release got=%b exp=0", out_valid); end
   endtask

   task automatic test_div_zero();
      int cyc;
      start_op(8'd5, 8'd0, 1'b0);
      wait_done(cyc);
      checks++; if (cyc != 1)              begin errors++; $display("FAIL dbz_latency got=%0d exp=1", cyc); end
      checks++; if (quotient !== 8'd255)   begin errors++; $display("FAIL dbz_quotient got=%0d exp=255", quotient); end
      checks++; if (remainder !== 8'd5)    begin errors++; $display("FAIL dbz_remainder got=%0d exp=5", remainder); end
      checks++; if (div_by_zero !== 1'b1)  begin errors++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
      handoff();
   endtask

   task automatic test_back_to_back();
      int cyc;
      start_op(8'd3, 8'd10, 1'b0);
      wait_done(cyc);
      checks++; if (quotient !== 8'd0)    begin errors++; $display("FAIL b2b1_quotient got=%0d exp=0", quotient); end
      checks++; if (remainder !== 8'd3)   begin errors++; $display("FAIL b2b1_remainder got=%0d exp=3", remainder); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL b2b1_dbz got=%b exp=0", div_by_zero); end
      // Next operation already pending while the first result is handed off
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; dividend = 8'd255; divisor = 8'd1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL b2b_idle_ready got=%b exp=1", in_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL b2b_second_accept got=%b exp=0", in_ready); end
      wait_done(cyc);
      checks++; if (cyc != 8)             begin errors++; $display("FAIL b2b2_latency got=%0d exp=8", cyc); end
      checks++; if (quotient !== 8'd255)  begin errors++; $display("FAIL b2b2_quotient got=%0d exp=255", quotient); end
      checks++; if (remainder !== 8'd0)   begin errors++; $display("FAIL b2b2_remainder got=%0d exp=0", remainder); end
      handoff();
   endtask

   task automatic test_stall();
      int cyc;
      start_op(8'd100, 8'd9, 1'b0);
      wait_done(cyc);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (quotient !== 8'd11)  begin errors++; $display("FAIL stall_quotient[%0d] got=%0d exp=11", i, quotient); end
         checks++; if (remainder !== 8'd1)  begin errors++; $display("FAIL stall_remainder[%0d] got=%0d exp=1", i, remainder); end
         checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
      end
      handoff();
      checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL stall_release got=%b exp=0", out_valid); end
      checks++; if (quotient !== 8'd11)   begin errors++; $display("FAIL stall_hold_quotient got=%0d exp=11", quotient); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      int pulses;
      start_op(8'd200, 8'd7, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
      checks++; if (quotient !== 8'd0)    begin errors++; $display("FAIL rmid_quotient got=%0d exp=0", quotient); end
      checks++; if (remainder !== 8'd0)   begin errors++; $display("FAIL rmid_remainder got=%0d exp=0", remainder); end
      checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid !== 1'b0) pulses++;
      end
      checks++; if (pulses != 0)          begin errors++; $display("FAIL rmid_no_pulse got=%0d exp=0", pulses); end
      start_op(8'd50, 8'd5, 1'b0);
      wait_done(cyc);
      checks++; if (cyc != 8)             begin errors++; $display("FAIL fresh_latency got=%0d exp=8", cyc); end
      checks++; if (quotient !== 8'd10)   begin errors++; $display("FAIL fresh_quotient got=%0d exp=10", quotient); end
      checks++; if (remainder !== 8'd0)   begin errors++; $display("FAIL fresh_remainder got=%0d exp=0", remainder); end
      handoff();
   endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
   task automatic test_signed();
      int cyc;
      start_op(8'hF9, 8'h02, 1'b1);
      wait_done(cyc);
      checks++; if (cyc != 8)             begin errors++; $display("FAIL s1_latency got=%0d exp=8", cyc); end
      checks++; if (quotient !== 8'hFD)   begin errors++; $display("FAIL s1_quotient got=%h exp=fd", quotient); end
      checks++; if (remainder !== 8'hFF)  begin errors++; $display("FAIL s1_remainder got=%h exp=ff", remainder); end
      handoff();
      start_op(8'h80, 8'hFF, 1'b1);
      wait_done(cyc);
      checks++; if (quotient !== 8'h80)   begin errors++; $display("FAIL s2_quotient got=%h exp=80", quotient); end
      checks++; if (remainder !== 8'h00)  begin errors++; $display("FAIL s2_remainder got=%h exp=00", remainder); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL s2_dbz got=%b exp=0", div_by_zero); end
      handoff();
   endtask
`endif

   initial begin
      test_reset();
      test_normal();
      test_div_zero();
      test_back_to_back();
      test_stall();
      test_reset_mid();
`ifdef SEQ_DIVIDER_SIGNED_EN
      test_signed();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
